// File: rtl/vrased_pkg.sv
// rtl/vrased_pkg.sv - shared states, cause bit positions and region index helper for the region monitor
package vrased_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ATOM = 2'd1,
        ST_VIOL = 2'd2
    } vrased_state_e;

    localparam int CAUSE_RD     = 0;
    localparam int CAUSE_WR     = 1;
    localparam int CAUSE_DMA    = 2;
    localparam int CAUSE_ATOM   = 3;
    localparam int CAUSE_IRQ    = 4;
    localparam int CAUSE_W      = 5;
    localparam int REGION_IDX_W = 3;

    // Lowest set bit wins so the diagnostic points at the lowest-numbered offender.
    function automatic logic [REGION_IDX_W-1:0] lowest_set(input logic [7:0] v);
        logic [REGION_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = REGION_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vrased_region_cmp.sv
// rtl/vrased_region_cmp.sv - inclusive unsigned range compare; base > limit disables the region
module vrased_region_cmp #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    output logic              hit
);

    assign hit = (base <= limit) && (addr >= base) && (addr <= limit);

endmodule

// File: rtl/vrased_region_monitor.sv
// rtl/vrased_region_monitor.sv - multi-region access, atomicity and DMA monitor; VRASED_IRQ_CHECK_EN enables irq-in-ATOM check
module vrased_region_monitor
    import vrased_pkg::*;
#(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            ADDR_W      = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REG_BASE    = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REG_LIMIT   = '0,
    parameter logic [NUM_REGIONS-1:0]        REG_RD_PROT = '0,
    parameter logic [NUM_REGIONS-1:0]        REG_WR_PROT = '0,
    parameter logic [ADDR_W-1:0]             ATOM_BASE   = 16'hA000,
    parameter logic [ADDR_W-1:0]             ATOM_LIMIT  = 16'hDFFE,
    parameter logic [ADDR_W-1:0]             ATOM_EXIT   = 16'hDFFE,
    parameter logic [ADDR_W-1:0]             RESET_PC    = 16'h0000,
    parameter int                            RST_HOLD    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       pc,
    input  logic                    data_en,
    input  logic                    data_wr,
    input  logic [ADDR_W-1:0]       data_addr,
    input  logic                    dma_en,
    input  logic [ADDR_W-1:0]       dma_addr,
    input  logic                    irq,
    output logic                    viol_rst,
    output logic                    in_atom,
    output logic [CAUSE_W-1:0]      viol_cause,
    output logic [REGION_IDX_W-1:0] viol_region
);

    localparam int                     CNT_W     = $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]       HOLD_SAT  = CNT_W'(RST_HOLD);
    localparam logic [NUM_REGIONS-1:0] ANY_PROT  = REG_RD_PROT | REG_WR_PROT;

    vrased_state_e           state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0]       pc_prev;
    logic [CAUSE_W-1:0]      cause_q, cause_nxt, cause_now;
    logic [REGION_IDX_W-1:0] region_q, region_nxt;

    logic [NUM_REGIONS-1:0]  data_hit, dma_hit;
    logic [NUM_REGIONS-1:0]  rd_viol, wr_viol, dma_reg_viol;
    logic                    pc_atom, dma_atom_hit;
    logic                    atom_viol, irq_viol, any_viol;

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        vrased_region_cmp #(.ADDR_W(ADDR_W)) u_data_cmp (
            .addr  (data_addr),
            .base  (REG_BASE[r*ADDR_W +: ADDR_W]),
            .limit (REG_LIMIT[r*ADDR_W +: ADDR_W]),
            .hit   (data_hit[r])
        );
        vrased_region_cmp #(.ADDR_W(ADDR_W)) u_dma_cmp (
            .addr  (dma_addr),
            .base  (REG_BASE[r*ADDR_W +: ADDR_W]),
            .limit (REG_LIMIT[r*ADDR_W +: ADDR_W]),
            .hit   (dma_hit[r])
        );
    end

    vrased_region_cmp #(.ADDR_W(ADDR_W)) u_pc_atom_cmp (
        .addr  (pc),
        .base  (ATOM_BASE),
        .limit (ATOM_LIMIT),
        .hit   (pc_atom)
    );

    vrased_region_cmp #(.ADDR_W(ADDR_W)) u_dma_atom_cmp (
        .addr  (dma_addr),
        .base  (ATOM_BASE),
        .limit (ATOM_LIMIT),
        .hit   (dma_atom_hit)
    );

    // CPU accesses to protected regions are only legal from inside the trusted code.
    assign rd_viol      = (data_en && !data_wr && state != ST_ATOM) ? (data_hit & REG_RD_PROT) : '0;
    assign wr_viol      = (data_en &&  data_wr && state != ST_ATOM) ? (data_hit & REG_WR_PROT) : '0;
    assign dma_reg_viol = dma_en ? (dma_hit & ANY_PROT) : '0;

    assign atom_viol = (state == ST_RUN  &&  pc_atom && pc != ATOM_BASE) ||
                       (state == ST_ATOM && !pc_atom && pc_prev != ATOM_EXIT);

`ifdef VRASED_IRQ_CHECK_EN
    assign irq_viol = irq && (state == ST_ATOM);
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_viol   = 1'b0;
`endif

    always_comb begin
        cause_now             = '0;
        cause_now[CAUSE_RD]   = |rd_viol;
        cause_now[CAUSE_WR]   = |wr_viol;
        cause_now[CAUSE_DMA]  = (|dma_reg_viol) || (dma_en && dma_atom_hit);
        cause_now[CAUSE_ATOM] = atom_viol;
        cause_now[CAUSE_IRQ]  = irq_viol;
    end

    assign any_viol = |cause_now;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cause_nxt  = cause_q;
        region_nxt = region_q;
        case (state)
            ST_RUN, ST_ATOM: begin
                // A violation outranks a simultaneous legal entry or exit.
                if (any_viol) begin
                    state_nxt  = ST_VIOL;
                    cnt_nxt    = '0;
                    cause_nxt  = cause_now;
                    region_nxt = lowest_set(8'(rd_viol | wr_viol | dma_reg_viol));
                end else if (state == ST_RUN && pc_atom && pc == ATOM_BASE) begin
                    state_nxt = ST_ATOM;
                end else if (state == ST_ATOM && !pc_atom && pc_prev == ATOM_EXIT) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_VIOL: begin
                if (cnt != HOLD_SAT) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                if (cnt >= HOLD_LAST && pc == RESET_PC) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            cnt      <= '0;
            pc_prev  <= RESET_PC;
            cause_q  <= '0;
            region_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pc_prev  <= pc;
            cause_q  <= cause_nxt;
            region_q <= region_nxt;
        end
    end

    assign viol_rst    = (state == ST_VIOL);
    assign in_atom     = (state == ST_ATOM);
    assign viol_cause  = cause_q;
    assign viol_region = region_q;

endmodule

// File: doc/vrased_region_monitor.md
# vrased_region_monitor

Parametrised successor to the single-region VRASED hardware monitor. It watches the MSP430 core's `pc`, CPU data bus, DMA bus and `irq`, and enforces three rules: access control over `NUM_REGIONS` configurable protected regions, atomic entry and exit of one trusted code region, and an exclusion on DMA access. On any violation it raises a registered, stretched system-reset request and keeps a sticky diagnostic record.

## Interface
- `NUM_REGIONS`, 4: number of protected data regions, 1..8.
- `ADDR_W`, 16: address width of `pc`, data and DMA buses.
- `REG_BASE`, {NUM_REGIONS{16'h0000}}: flattened inclusive base addresses; region r is `[r*ADDR_W +: ADDR_W]`.
- `REG_LIMIT`, {NUM_REGIONS{16'h0000}}: flattened inclusive limits. A region with base > limit is disabled.
- `REG_RD_PROT`, 0: bit r set means CPU reads of region r are legal only in state ATOM.
- `REG_WR_PROT`, 0: bit r set means CPU writes to region r are legal only in state ATOM.
- `ATOM_BASE`, 16'hA000: first address of the trusted code region, and its only legal entry point.
- `ATOM_LIMIT`, 16'hDFFE: last address of the trusted code region.
- `ATOM_EXIT`, 16'hDFFE: only address from which `pc` may leave the trusted region.
- `RESET_PC`, 16'h0000: `pc` value that releases the reset request.
- `RST_HOLD`, 4: minimum number of cycles `viol_rst` stays high, ≥1.
- Ports:
  - `clk` in 1: the single clock.
  - `reset` in 1: synchronous, active-high.
  - `pc` in ADDR_W: current program counter.
  - `data_en` in 1: CPU data access this cycle.
  - `data_wr` in 1: the CPU access is a write.
  - `data_addr` in ADDR_W: CPU data address.
  - `dma_en` in 1: DMA access this cycle.
  - `dma_addr` in ADDR_W: DMA address.
  - `irq` in 1: interrupt request.
  - `viol_rst` out 1: system reset request.
  - `in_atom` out 1: state is ATOM.
  - `viol_cause` out 5: sticky cause. Bit 0 is CPU read, bit 1 CPU write, bit 2 DMA, bit 3 atomicity, bit 4 irq.
  - `viol_region` out 3: sticky index of the offending region.

## Operation
- Region hit: `lo ≤ addr ≤ hi`, unsigned compare with inclusive bounds, evaluated separately for each enabled region.
- FSM states are RUN, ATOM and VIOL.
- Transitions from RUN:
  - `pc` inside `[ATOM_BASE, ATOM_LIMIT]` with `pc == ATOM_BASE` goes to ATOM.
  - `pc` inside the region at any other address is an atomicity violation and goes to VIOL.
- Transitions from ATOM:
  - `pc` outside the region with `pc_prev == ATOM_EXIT` goes to RUN.
  - `pc` outside the region with any other `pc_prev` is an atomicity violation and goes to VIOL.
- `pc_prev` is `pc` registered. Its reset value is `RESET_PC`.
- Violations, evaluated in RUN and ATOM:
  - CPU read: `data_en & ~data_wr`, hit on region r, `REG_RD_PROT[r]`, and state ≠ ATOM.
  - CPU write: same, with `data_wr` and `REG_WR_PROT[r]`.
  - DMA: `dma_en` hitting any enabled region that has a RD or WR protection bit, or hitting `[ATOM_BASE, ATOM_LIMIT]`. This is illegal in every state.
  - irq: see Configuration.
- Any violation moves the FSM to VIOL.
  - `viol_cause` latches the OR of every cause active in that cycle.
  - `viol_region` latches the lowest-numbered offending region; it is 0 for atomicity-only or irq-only violations.
- VIOL behaviour:
  - The hold counter counts up from 0.
  - The FSM leaves VIOL for RUN when counter ≥ `RST_HOLD-1` and `pc == RESET_PC`.
  - New violations in VIOL are ignored; the cause and region values stay frozen.
- `viol_cause` and `viol_region` clear only on `reset`. A later violation overwrites them.
- The hold counter saturates. It is sized `$clog2(RST_HOLD+1)`.

## Timing
- Reset values: state RUN; `viol_rst` 0, `in_atom` 0, `viol_cause` 0, `viol_region` 0, counter 0.
- A violation on inputs sampled at edge N gives `viol_rst = 1` and cause/region valid after edge N, i.e. one cycle of latency.
- `viol_rst` is high for at least `RST_HOLD` cycles. It deasserts the cycle after the exit condition.
- `in_atom` rises the cycle after `pc == ATOM_BASE` is sampled.
- A `reset` asserted mid-VIOL or mid-ATOM wins unconditionally on that edge.
- When a legal entry to ATOM and a violation occur in the same cycle, VIOL wins.

## Configuration
- `VRASED_IRQ_CHECK_EN` defined: `irq` sampled high while the state is ATOM is a violation and sets `viol_cause[4]`.
- `VRASED_IRQ_CHECK_EN` undefined: `irq` is ignored, and `viol_cause[4]` is tied to 0.

## Structure
- Package `vrased_pkg`:
  - state enum.
  - cause bit index constants.
  - `REGION_IDX_W = 3`.
- One sub-module, `vrased_region_cmp`:
  - one instance per region, built with a generate loop.
  - inputs: address, base, limit.
  - output: hit. A disabled region never hits.

## Test plan
Configuration under test:
- Region 0: `6A00`–`6A3F`, RD and WR protected.
- Region 1: `0440`–`04FF`, WR protected.
- Atomic region `A000`–`DFFE`, `RST_HOLD=4`, `VRASED_IRQ_CHECK_EN` defined.

Scenarios:
- Reset release, `pc=0000`, `data_en=1`, `data_wr=0`, `data_addr=6A00` → next cycle `viol_rst=1`, `viol_cause=00001`, `viol_region=0`.
- `pc=A000`, then `pc=A002` with a read of `6A10` → no violation and `in_atom=1`. Then `pc_prev=DFFE`, `pc=0100` → `in_atom=0`, no violation.
- `pc` jumps from `0100` to `A004` → `viol_cause=01000`. `viol_rst` stays high for ≥4 cycles and drops one cycle after the counter is ≥3 and `pc=0000`.
- `dma_en=1`, `dma_addr=6A00` in RUN; separately `dma_addr=B000` in ATOM → each run gives `viol_cause=00100`.
- Same-cycle CPU write to `0440` and DMA to `6A00` in RUN → `viol_cause=00110`, `viol_region=0`.
- `irq=1` in ATOM → `viol_cause=10000`. With the macro undefined → no violation.
